// File: rtl/phys_free_list.sv
// Physical-register free list for rename: a ring of unmapped tags with a speculative
// and a committed head, so a flush rewinds every allocation made since the last commit.
module phys_free_list #(
    parameter int NUM_ARCH_REGS = 35,
    parameter int NUM_PHYS_REGS = 64,
    localparam int DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS,
    localparam int PW    = $clog2(NUM_PHYS_REGS),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alloc_req,
    output logic          alloc_valid,
    output logic [PW-1:0] alloc_preg,
    input  logic          free_valid,
    input  logic [PW-1:0] free_preg,
    input  logic          commit_alloc,
    input  logic          flush,
    output logic [CW-1:0] free_count,
    output logic          err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef logic [AW-1:0] ptr_t;

    // Ring depth is not a power of two, so wrap explicitly.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [PW-1:0] mem [DEPTH];
    ptr_t          spec_head, commit_head, tail;
    logic [CW-1:0] spec_count, commit_count;

    logic          alloc_fire, free_acc, free_err, commit_acc, commit_err;
    ptr_t          spec_head_next, commit_head_next;
    logic [CW-1:0] spec_count_next, commit_count_next;

    assign alloc_valid = (spec_count != '0);
    assign alloc_preg  = mem[spec_head];
    assign free_count  = spec_count;

    always_comb begin
        alloc_fire = alloc_req && alloc_valid && !flush;
        free_acc   = free_valid && (commit_count != DEPTH_C);
        free_err   = free_valid && (commit_count == DEPTH_C);
        commit_acc = commit_alloc && (commit_count != '0);
        commit_err = commit_alloc && (commit_count == '0);

        commit_head_next  = commit_acc ? ptr_inc(commit_head) : commit_head;
        commit_count_next = commit_count + CW'(free_acc) - CW'(commit_acc);

        // A flush adopts the committed view after this cycle's free/commit are applied.
        if (flush) begin
            spec_head_next  = commit_head_next;
            spec_count_next = commit_count_next;
        end else begin
            spec_head_next  = alloc_fire ? ptr_inc(spec_head) : spec_head;
            spec_count_next = spec_count + CW'(free_acc) - CW'(alloc_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= PW'(NUM_ARCH_REGS + i);
            end
            spec_head    <= '0;
            commit_head  <= '0;
            tail         <= '0;
            spec_count   <= DEPTH_C;
            commit_count <= DEPTH_C;
            err          <= 1'b0;
        end else begin
            if (free_acc) begin
                mem[tail] <= free_preg;
                tail      <= ptr_inc(tail);
            end
            spec_head    <= spec_head_next;
            commit_head  <= commit_head_next;
            spec_count   <= spec_count_next;
            commit_count <= commit_count_next;
            err          <= err | free_err | commit_err;
        end
    end
endmodule

// File: tb/tb_phys_free_list.sv
// Bench for phys_free_list: directed vector table, hand-written corner sequences,
// and random traffic compared against a queue-based model of the free lists.
module tb_phys_free_list;
    localparam int NA    = 35;
    localparam int NP    = 64;
    localparam int DEPTH = NP - NA;

    logic       clk = 1'b0;
    logic       reset;
    logic       alloc_req;
    logic       alloc_valid;
    logic [5:0] alloc_preg;
    logic       free_valid;
    logic [5:0] free_preg;
    logic       commit_alloc;
    logic       flush;
    logic [4:0] free_count;
    logic       err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    phys_free_list dut (
        .clk(clk), .reset(reset), .alloc_req(alloc_req), .alloc_valid(alloc_valid),
        .alloc_preg(alloc_preg), .free_valid(free_valid), .free_preg(free_preg),
        .commit_alloc(commit_alloc), .flush(flush), .free_count(free_count), .err(err)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        reset = 0; alloc_req = 0; free_valid = 0; free_preg = '0;
        commit_alloc = 0; flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    typedef struct {
        logic       rst, areq, fv, ca, fl;
        logic [5:0] fpreg;
        logic       e_av;
        int         e_preg, e_cnt;
        logic       e_err;
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input logic rst, input logic areq, input logic fv, input int fp,
                           input logic ca, input logic fl, input logic av, input int pr,
                           input int cnt, input logic e);
        vec_t v;
        v.rst = rst; v.areq = areq; v.fv = fv; v.fpreg = 6'(fp); v.ca = ca; v.fl = fl;
        v.e_av = av; v.e_preg = pr; v.e_cnt = cnt; v.e_err = e;
        vecs.push_back(v);
    endtask

    // Reference model: spec_q is the speculative free list, commit_q the committed one.
    int   spec_q[$];
    int   commit_q[$];
    logic m_err;

    function automatic void model_reset();
        spec_q.delete();
        commit_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            spec_q.push_back(NA + i);
            commit_q.push_back(NA + i);
        end
        m_err = 0;
    endfunction

    function automatic void model_step(input logic areq, input logic fv, input int fp,
                                       input logic ca, input logic fl);
        logic fire, facc, cacc;
        fire = areq && (spec_q.size() > 0) && !fl;
        facc = fv && (commit_q.size() < DEPTH);
        cacc = ca && (commit_q.size() > 0);
        if (fv && !facc) m_err = 1;
        if (ca && !cacc) m_err = 1;
        if (facc) commit_q.push_back(fp);
        if (cacc) void'(commit_q.pop_front());
        if (fl) begin
            spec_q = commit_q;
        end else begin
            if (fire) void'(spec_q.pop_front());
            if (facc) spec_q.push_back(fp);
        end
    endfunction

    task automatic check_model(input string tag);
        check({tag, "_alloc_valid"}, int'(alloc_valid), int'(spec_q.size() > 0));
        if (spec_q.size() > 0) check({tag, "_alloc_preg"}, int'(alloc_preg), spec_q[0]);
        check({tag, "_free_count"}, int'(free_count), spec_q.size());
        check({tag, "_err"}, int'(err), int'(m_err));
        check({tag, "_count_le_commit"}, int'(int'(free_count) <= commit_q.size()), 1);
    endtask

    task automatic random_cycles(input int n, input string tag);
        for (int c = 0; c < n; c++) begin
            int   pool[$];
            logic in_list;
            logic areq, fv, ca, fl;
            int   fp;
            check_model(tag);
            // Tags not on the committed list are mapped and may legally be released.
            for (int t = 0; t < NP; t++) begin
                in_list = 0;
                foreach (commit_q[k]) if (commit_q[k] == t) in_list = 1;
                if (!in_list) pool.push_back(t);
            end
            areq = ($urandom_range(99, 0) < 60);
            fv   = (pool.size() > 0) && ($urandom_range(99, 0) < 35);
            fp   = (pool.size() > 0) ? pool[$urandom_range(pool.size() - 1, 0)] : 0;
            ca   = (commit_q.size() > spec_q.size()) && ($urandom_range(99, 0) < 40);
            fl   = ($urandom_range(99, 0) < 6);
            alloc_req = areq; free_valid = fv; free_preg = 6'(fp);
            commit_alloc = ca; flush = fl;
            @(posedge clk);
            model_step(areq, fv, fp, ca, fl);
            #1;
            idle_inputs();
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        tick();
        tick();

        // Directed vectors: reset state, flush recovery, full-push error, flush+commit.
        add_vec(1, 0, 0, 0, 0, 0, 1, 35, 29, 0);
        add_vec(0, 1, 0, 0, 0, 0, 1, 36, 28, 0);
        add_vec(0, 1, 0, 0, 0, 0, 1, 37, 27, 0);
        add_vec(0, 1, 0, 0, 0, 0, 1, 38, 26, 0);
        add_vec(0, 0, 0, 0, 1, 0, 1, 38, 26, 0);
        add_vec(0, 0, 0, 0, 0, 1, 1, 36, 28, 0);
        add_vec(1, 1, 1, 9, 1, 1, 1, 35, 29, 0);
        add_vec(0, 0, 1, 3, 0, 0, 1, 35, 29, 1);
        add_vec(0, 1, 0, 0, 0, 0, 1, 36, 28, 1);
        add_vec(1, 0, 0, 0, 0, 0, 1, 35, 29, 0);
        add_vec(0, 1, 0, 0, 0, 0, 1, 36, 28, 0);
        add_vec(0, 1, 0, 0, 0, 0, 1, 37, 27, 0);
        add_vec(0, 1, 0, 0, 1, 1, 1, 36, 28, 0);
        add_vec(0, 1, 0, 0, 0, 1, 1, 36, 28, 0);
        foreach (vecs[i]) begin
            reset = vecs[i].rst; alloc_req = vecs[i].areq; free_valid = vecs[i].fv;
            free_preg = vecs[i].fpreg; commit_alloc = vecs[i].ca; flush = vecs[i].fl;
            tick();
            idle_inputs();
            check($sformatf("vec%0d_alloc_valid", i), int'(alloc_valid), int'(vecs[i].e_av));
            check($sformatf("vec%0d_alloc_preg", i), int'(alloc_preg), vecs[i].e_preg);
            check($sformatf("vec%0d_free_count", i), int'(free_count), vecs[i].e_cnt);
            check($sformatf("vec%0d_err", i), int'(err), int'(vecs[i].e_err));
        end

        // Drain: 30 cycles of alloc_req grant 35..63, then nothing.
        do_reset();
        alloc_req = 1;
        for (int k = 0; k < 30; k++) begin
            if (k < 29) begin
                check("drain_valid", int'(alloc_valid), 1);
                check("drain_preg", int'(alloc_preg), 35 + k);
                check("drain_count", int'(free_count), 29 - k);
            end else begin
                check("drain_empty_valid", int'(alloc_valid), 0);
                check("drain_empty_count", int'(free_count), 0);
            end
            tick();
        end
        alloc_req = 0;
        check("drain_after_valid", int'(alloc_valid), 0);
        check("drain_after_count", int'(free_count), 0);
        check("drain_after_err", int'(err), 0);

        // Commit all 29 allocations, then one more is an underflow.
        commit_alloc = 1;
        for (int k = 0; k < 29; k++) tick();
        commit_alloc = 0;
        check("commit_all_err", int'(err), 0);
        check("commit_all_count", int'(free_count), 0);
        commit_alloc = 1;
        tick();
        commit_alloc = 0;
        check("underflow_err", int'(err), 1);
        check("underflow_count", int'(free_count), 0);

        // Free into empty: no bypass in the same cycle.
        free_valid = 1; free_preg = 6'd7;
        #1;
        check("free_empty_same_valid", int'(alloc_valid), 0);
        tick();
        free_valid = 0;
        check("free_empty_next_valid", int'(alloc_valid), 1);
        check("free_empty_next_preg", int'(alloc_preg), 7);
        check("free_empty_next_count", int'(free_count), 1);

        // At count 1, alloc and free together keep the count at 1.
        alloc_req = 1; free_valid = 1; free_preg = 6'd5;
        #1;
        check("simul_grant_preg", int'(alloc_preg), 7);
        tick();
        idle_inputs();
        check("simul_count", int'(free_count), 1);
        check("simul_valid", int'(alloc_valid), 1);
        check("simul_next_preg", int'(alloc_preg), 5);

        // Random traffic, then reset mid-operation.
        do_reset();
        model_reset();
        random_cycles(10, "rnd_pre");
        alloc_req = 1; free_valid = 1; free_preg = 6'd2; flush = 1; reset = 1;
        tick();
        idle_inputs();
        model_reset();
        check("midreset_preg", int'(alloc_preg), 35);
        check("midreset_count", int'(free_count), 29);
        check("midreset_err", int'(err), 0);
        random_cycles(600, "rnd");
        check_model("rnd_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
